snitch_icache_refill_writer: RTL

Miss handler and refill writer for the parallel icache lookup stage. It accepts one lookup miss at a time and fetches the full line from the refill port. It then drives the line into the lookup stage's RAM write port at a chosen victim set, and returns the line to the fetch side in parallel. It is the write-side counterpart of the lookup: the lookup reads tag/data, this block produces write_addr/set/data/tag/error.

---
 rtl/snitch_icache_refill_writer.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/snitch_icache_refill_writer.sv
// -----------------------------------------------------------------------------
// snitch_icache_refill_writer
//
// Miss handler and refill writer for the parallel icache lookup stage. It
// takes one lookup miss at a time, requests the line-aligned address on the
// refill port, and captures the returned line. It then offers the line twice
// in parallel: once to the lookup stage's RAM write port at a chosen victim
// way, and once back to the fetch side as the miss response.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   miss_*                  miss request from lookup (addr, id, valid/ready)
//   refill_q*               refill request (line-aligned address)
//   refill_p*               refill response (line data, bus error)
//   write_*                 RAM write port (index, way, data, tag, error)
//   rsp_*                   miss response to fetch (data, error, id)
//
// Optional feature
//   SNITCH_ICACHE_LFSR_VICTIM_EN  when defined, the victim way comes from the
//                                 low bits of an 8-bit Fibonacci LFSR instead
//                                 of a round-robin counter.
// -----------------------------------------------------------------------------
module snitch_icache_refill_writer #(
   parameter int unsigned FETCH_AW    = 32,
   parameter int unsigned LINE_WIDTH  = 128,
   parameter int unsigned LINE_ALIGN  = 4,
   parameter int unsigned COUNT_ALIGN = 5,
   parameter int unsigned SET_COUNT   = 4,
   parameter int unsigned SET_ALIGN   = 2,
   parameter int unsigned TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN,
   parameter int unsigned ID_WIDTH    = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,

   input  logic [FETCH_AW-1:0]    miss_addr_i,
   input  logic [ID_WIDTH-1:0]    miss_id_i,
   input  logic                   miss_valid_i,
   output logic                   miss_ready_o,

   output logic [FETCH_AW-1:0]    refill_qaddr_o,
   output logic                   refill_qvalid_o,
   input  logic                   refill_qready_i,

   input  logic [LINE_WIDTH-1:0]  refill_pdata_i,
   input  logic                   refill_perror_i,
   input  logic                   refill_pvalid_i,
   output logic                   refill_pready_o,

   output logic [COUNT_ALIGN-1:0] write_addr_o,
   output logic [SET_ALIGN-1:0]   write_set_o,
   output logic [LINE_WIDTH-1:0]  write_data_o,
   output logic [TAG_WIDTH-1:0]   write_tag_o,
   output logic                   write_error_o,
   output logic                   write_valid_o,
   input  logic                   write_ready_i,

   output logic [LINE_WIDTH-1:0]  rsp_data_o,
   output logic                   rsp_error_o,
   output logic [ID_WIDTH-1:0]    rsp_id_o,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_WRITE
   } state_e;

   // Clears the byte-within-line bits while still consuming every address bit.
   localparam logic [FETCH_AW-1:0] LINE_MASK =
      ~((FETCH_AW'(1) << LINE_ALIGN) - FETCH_AW'(1));

   state_e                  state_q, state_d;
   logic [FETCH_AW-1:0]     addr_q, addr_d;
   logic [ID_WIDTH-1:0]     id_q, id_d;
   logic [LINE_WIDTH-1:0]   data_q, data_d;
   logic                    error_q, error_d;
   logic [SET_ALIGN-1:0]    set_q, set_d;
   logic                    wr_done_q, wr_done_d;
   logic                    rsp_done_q, rsp_done_d;

   logic                    wr_fire;
   logic                    rsp_fire;
   logic [SET_ALIGN-1:0]    victim;

   // ---------------------------------------------------------------------------
   // Victim selection. Advances only on the RAM write handshake; the way used
   // for the current line is latched separately into set_q.
   // ---------------------------------------------------------------------------
`ifdef SNITCH_ICACHE_LFSR_VICTIM_EN
   logic [7:0] lfsr_q, lfsr_d;

   assign victim = lfsr_q[SET_ALIGN-1:0];

   always_comb begin
      lfsr_d = lfsr_q;
      if (wr_fire) begin
         lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q <= 8'h01;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   logic [SET_ALIGN-1:0] cnt_q, cnt_d;

   assign victim = cnt_q;

   // Natural wrap of the SET_ALIGN-bit counter gives SET_COUNT-1 -> 0.
   always_comb begin
      cnt_d = cnt_q;
      if (wr_fire) begin
         cnt_d = cnt_q + SET_ALIGN'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Outputs: all decoded from registered state, so no input reaches an output
   // combinationally.
   // ---------------------------------------------------------------------------
   assign miss_ready_o    = (state_q == S_IDLE);
   assign refill_qvalid_o = (state_q == S_REQ);
   assign refill_qaddr_o  = addr_q & LINE_MASK;
   assign refill_pready_o = (state_q == S_WAIT);

   assign write_valid_o   = (state_q == S_WRITE) && !wr_done_q;
   assign write_addr_o    = addr_q[LINE_ALIGN +: COUNT_ALIGN];
   assign write_tag_o     = addr_q[FETCH_AW-1 : LINE_ALIGN+COUNT_ALIGN];
   assign write_set_o     = set_q;
   assign write_data_o    = data_q;
   // An erroring line is still written so later lookups see the error too.
   assign write_error_o   = error_q;

   assign rsp_valid_o     = (state_q == S_WRITE) && !rsp_done_q;
   assign rsp_data_o      = data_q;
   assign rsp_error_o     = error_q;
   assign rsp_id_o        = id_q;

   assign wr_fire  = write_valid_o && write_ready_i;
   assign rsp_fire = rsp_valid_o && rsp_ready_i;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; otherwise synthesis would infer a latch.
      state_d    = state_q;
      addr_d     = addr_q;
      id_d       = id_q;
      data_d     = data_q;
      error_d    = error_q;
      set_d      = set_q;
      wr_done_d  = wr_done_q;
      rsp_done_d = rsp_done_q;

      unique case (state_q)
         S_IDLE: begin
            if (miss_valid_i) begin
               addr_d  = miss_addr_i;
               id_d    = miss_id_i;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (refill_qready_i) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (refill_pvalid_i) begin
               data_d     = refill_pdata_i;
               error_d    = refill_perror_i;
               set_d      = victim;
               wr_done_d  = 1'b0;
               rsp_done_d = 1'b0;
               state_d    = S_WRITE;
            end
         end
         S_WRITE: begin
            // Each channel completes on its own; leave once both have, which
            // also covers both handshaking in the same cycle.
            if (wr_fire) begin
               wr_done_d = 1'b1;
            end
            if (rsp_fire) begin
               rsp_done_d = 1'b1;
            end
            if (wr_done_d && rsp_done_d) begin
               wr_done_d  = 1'b0;
               rsp_done_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst_i) begin
         state_q    <= S_IDLE;
         // NOTE: payload registers are reset as well, so outputs read as zero
         // after reset instead of carrying stale line data.
         addr_q     <= '0;
         id_q       <= '0;
         data_q     <= '0;
         error_q    <= 1'b0;
         set_q      <= '0;
         wr_done_q  <= 1'b0;
         rsp_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         id_q       <= id_d;
         data_q     <= data_d;
         error_q    <= error_d;
         set_q      <= set_d;
         wr_done_q  <= wr_done_d;
         rsp_done_q <= rsp_done_d;
      end
   end

endmodule
